rf_writeback_arbiter: RTL and testbench
=======================================

# rf_writeback_arbiter

Write-side front end of the 32 × 32 RV32IM register file. It merges the in-order pipeline writeback stream and out-of-order results from the multi-cycle M-unit (multiply/divide) onto the register file's single write port (WE3/A3/WD3). A small FIFO buffers M-unit results until the write port is free. A per-register scoreboard tells the hazard unit which destination registers still have an M-unit result outstanding.

## Interface
- DEPTH, 2, M-unit result FIFO entries; power of two, ≥2
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-low reset
- wb_valid  in  1  pipeline writeback valid; never stalled
- wb_rd  in  5  pipeline destination register
- wb_data  in  32  pipeline result
- md_issue  in  1  M-unit op dispatched this cycle
- md_issue_rd  in  5  destination of dispatched op
- md_valid  in  1  M-unit result valid
- md_rd  in  5  result destination
- md_data  in  32  result value
- md_ready  out  1  arbiter can accept a result
- rf_we  out  1  to register file WE3
- rf_waddr  out  5  to register file A3
- rf_wdata  out  32  to register file WD3
- pending  out  32  scoreboard; bit i = x_i awaiting M-unit writeback; bit 0 always 0
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Reset (rst=0 at clk edge): FIFO empty, fifo_count=0, pending=0. While rst=0: rf_we=0 and md_ready=0. rf_waddr/rf_wdata are 0 whenever rf_we=0.
- md_ready = rst && (fifo_count < DEPTH). It depends only on registered state, never on md_valid or a same-cycle pop. When full, nothing is pushed, even if the head drains in the same cycle.
- Accept: md_valid && md_ready.
  - md_rd≠0: push {md_rd, md_data} at the tail.
  - md_rd=0: consume and discard, with no push.
- Write-port priority (combinational, same cycle):
  1. wb_valid && wb_rd≠0: rf_we=1, rf_waddr=wb_rd, rf_wdata=wb_data.
  2. Otherwise, if FIFO is non-empty: pop the head, rf_we=1, rf_waddr=head.rd, rf_wdata=head.data.
  3. Otherwise rf_we=0.
- wb_valid with wb_rd=0 drives rf_we=0 and leaves the port free for a FIFO drain in that cycle.
- An accepted result is never written in its acceptance cycle. The FIFO has no bypass.
- FIFO: circular read/write pointers wrapping at DEPTH; strict FIFO order.
  - fifo_count changes by +1 (push only), −1 (pop only) or 0 (push and pop together). Push and pop together is legal only when not full.
- Scoreboard, per bit i (i≥1):
  - Set: md_issue && md_issue_rd==i.
  - Clear: FIFO pop with head.rd==i.
  - Set and clear of the same i in the same cycle: set wins.
  - md_issue with md_issue_rd=0 is ignored.
- The hazard unit stalls any instruction whose rs1, rs2 or rd has its pending bit set. Therefore no WAW/RAW ordering logic lives here.
- Starvation: continuous wb traffic blocks draining. This is bounded because the resulting pending-bit stalls inject pipeline bubbles.
- Protocol checker (simulation only): flag an error on push to a full FIFO, on pop of an empty FIFO, and on md_issue to an already-pending rd.

## Timing
- Pipeline writeback: zero-cycle pass-through to the rf_* outputs. The register file's same-cycle read bypass applies unchanged.
- M-unit result accepted at edge N:
  - Earliest rf_we is cycle N+1.
  - Its pending bit reads 0 from cycle N+2 (cleared at the N+1 edge).
- Each cycle of wb priority delays the head by one cycle.
- md_issue at edge N: pending bit reads 1 from cycle N+1.
- All state updates occur on the rising clk edge. Outputs other than md_ready and the rf_* signals are registered.

## Test plan
- Reset: hold rst=0 for 3 cycles with md_valid=1 and wb_valid=1 -> rf_we=0, md_ready=0, pending=0, fifo_count=0. After release -> md_ready=1.
- Basic drain: md_issue rd=5; two cycles later md_valid rd=5, data=0x0000_00C8, with wb idle -> next cycle rf_we=1, rf_waddr=5, rf_wdata=0xC8. pending[5] is 1 until that write, then 0.
- Priority: FIFO holds {7, 0x1234}; wb_valid rd=3, data=0xAAAA for 2 cycles -> rf writes x3 twice, then x7=0x1234 in the third cycle. fifo_count stays 1 until then.
- Full: DEPTH=2, wb_valid continuously with rd=1, push results for rd 8 and rd 9 -> fifo_count=2, md_ready=0, and a third md_valid is held off. Drop wb -> x8 then x9 are written in order, and md_ready returns to 1 after the first pop.
- Zero register: md_valid rd=0, data=0xDEAD -> accepted, fifo_count unchanged, no rf_we. wb_valid rd=0 while the FIFO is non-empty -> head drains in the same cycle.
- Simultaneous set/clear: head.rd=4 pops in the same cycle as md_issue rd=4 -> pending[4] stays 1. Wrap-around: 10 back-to-back push/pop pairs -> data emerges in order with no loss.

Source files
------------

// File: rtl/rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_writeback_arbiter
// Description : Merges pipeline writeback and buffered M-unit results onto the
//               single register-file write port; tracks outstanding M-unit rd.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_writeback_arbiter #(
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wb_valid,
    input  logic [4:0]                 wb_rd,
    input  logic [31:0]                wb_data,
    input  logic                       md_issue,
    input  logic [4:0]                 md_issue_rd,
    input  logic                       md_valid,
    input  logic [4:0]                 md_rd,
    input  logic [31:0]                md_data,
    output logic                       md_ready,
    output logic                       rf_we,
    output logic [4:0]                 rf_waddr,
    output logic [31:0]                rf_wdata,
    output logic [31:0]                pending,
    output logic [$clog2(DEPTH):0]     fifo_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full = (AW+1)'(DEPTH);

    logic [4:0]    r_mem_rd   [DEPTH];
    logic [31:0]   r_mem_data [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic [31:0]   r_pending;

    logic          w_wb_take;
    logic          w_push;
    logic          w_pop;
    logic          w_nonempty;
    logic [4:0]    w_head_rd;
    logic [31:0]   w_head_data;
    logic [31:0]   w_pending_nxt;

    // Readiness looks only at registered occupancy, so a full FIFO never
    // accepts even when its head drains this cycle.
    assign md_ready    = rst && (r_count < c_full);
    assign w_push      = md_valid && md_ready && (md_rd != 5'd0);
    assign w_nonempty  = (r_count != '0);
    assign w_wb_take   = wb_valid && (wb_rd != 5'd0);
    assign w_pop       = rst && !w_wb_take && w_nonempty;
    assign w_head_rd   = r_mem_rd[r_rptr];
    assign w_head_data = r_mem_data[r_rptr];

    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        rf_wdata = 32'd0;
        if (rst && w_wb_take) begin
            rf_we    = 1'b1;
            rf_waddr = wb_rd;
            rf_wdata = wb_data;
        end else if (w_pop) begin
            rf_we    = 1'b1;
            rf_waddr = w_head_rd;
            rf_wdata = w_head_data;
        end
    end

    // Set is applied after clear so a same-cycle reissue keeps the bit high.
    always_comb begin
        w_pending_nxt = r_pending;
        if (w_pop) begin
            w_pending_nxt[w_head_rd] = 1'b0;
        end
        if (md_issue) begin
            w_pending_nxt[md_issue_rd] = 1'b1;
        end
        w_pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_rd[r_wptr]   <= md_rd;
            r_mem_data[r_wptr] <= md_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_pending <= 32'd0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            r_pending <= w_pending_nxt;
        end
    end

    assign pending    = r_pending;
    assign fifo_count = r_count;

`ifndef SYNTHESIS
    a_no_push_full: assert property (@(posedge clk) disable iff (!rst)
        !(w_push && (r_count == c_full)));
    a_no_pop_empty: assert property (@(posedge clk) disable iff (!rst)
        !(w_pop && !w_nonempty));
    a_no_reissue: assert property (@(posedge clk) disable iff (!rst)
        !(md_issue && (md_issue_rd != 5'd0) && r_pending[md_issue_rd]
          && !(w_pop && (w_head_rd == md_issue_rd))));
`endif

endmodule
`default_nettype wire

// File: tb/tb_rf_writeback_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_writeback_arbiter
// Description : Directed scoreboard bench for rf_writeback_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_writeback_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = 5'd0;
    logic [31:0] wb_data = 32'd0;
    logic        md_issue = 1'b0;
    logic [4:0]  md_issue_rd = 5'd0;
    logic        md_valid = 1'b0;
    logic [4:0]  md_rd = 5'd0;
    logic [31:0] md_data = 32'd0;
    logic        md_ready;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [31:0] pending;
    logic [1:0]  fifo_count;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_cmp = 0;
    int  n_bad = 0;

    rf_writeback_arbiter #(.DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .wb_valid    (wb_valid),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .md_issue    (md_issue),
        .md_issue_rd (md_issue_rd),
        .md_valid    (md_valid),
        .md_rd       (md_rd),
        .md_data     (md_data),
        .md_ready    (md_ready),
        .rf_we       (rf_we),
        .rf_waddr    (rf_waddr),
        .rf_wdata    (rf_wdata),
        .pending     (pending),
        .fifo_count  (fifo_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every register-file write must match the head of the expected queue.
    always @(negedge clk) begin
        wr_t w;
        if (rf_we === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_write: got x%0d=0x%08h required no write", rf_waddr, rf_wdata);
            end else begin
                w = exp_q.pop_front();
                if (rf_waddr !== w.addr || rf_wdata !== w.data) begin
                    n_bad++;
                    $display("FAIL rf_write: got x%0d=0x%08h required x%0d=0x%08h",
                             rf_waddr, rf_wdata, w.addr, w.data);
                end
            end
        end else if (rf_we !== 1'b0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL rf_we_known: got %b required 0/1", rf_we);
        end else if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_port: got x%0d=0x%08h required x0=0x00000000", rf_waddr, rf_wdata);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with traffic on every input
        md_valid = 1'b1; md_rd = 5'd6; md_data = 32'h6666_6666;
        wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h2222_2222;
        md_issue = 1'b1; md_issue_rd = 5'd7;
        repeat (3) cyc();
        chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
        chk("reset_md_ready", {31'd0, md_ready}, 32'd0);
        chk("reset_pending", pending, 32'd0);
        chk("reset_fifo_count", {30'd0, fifo_count}, 32'd0);
        md_valid = 1'b0; wb_valid = 1'b0; md_issue = 1'b0;
        rst = 1'b1;
        #1;
        chk("release_md_ready", {31'd0, md_ready}, 32'd1);
        cyc();

        // Basic drain
        md_issue = 1'b1; md_issue_rd = 5'd5;
        cyc();
        md_issue = 1'b0;
        chk("issue_pending5", {31'd0, pending[5]}, 32'd1);
        cyc();
        md_valid = 1'b1; md_rd = 5'd5; md_data = 32'h0000_00C8;
        expect_wr(5'd5, 32'h0000_00C8);
        cyc();
        md_valid = 1'b0;
        chk("drain_count", {30'd0, fifo_count}, 32'd1);
        chk("drain_pending5_held", {31'd0, pending[5]}, 32'd1);
        cyc();
        chk("drain_pending5_clr", {31'd0, pending[5]}, 32'd0);
        chk("drain_count_empty", {30'd0, fifo_count}, 32'd0);

        // Priority: wb beats FIFO head for two cycles
        expect_wr(5'd3, 32'h0000_AAAA);
        expect_wr(5'd3, 32'h0000_AAAA);
        expect_wr(5'd7, 32'h0000_1234);
        md_valid = 1'b1; md_rd = 5'd7; md_data = 32'h0000_1234;
        cyc();
        md_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd3; wb_data = 32'h0000_AAAA;
        cyc();
        chk("prio_count_c1", {30'd0, fifo_count}, 32'd1);
        cyc();
        chk("prio_count_c2", {30'd0, fifo_count}, 32'd1);
        wb_valid = 1'b0;
        cyc();
        chk("prio_count_drained", {30'd0, fifo_count}, 32'd0);

        // Full FIFO under continuous wb traffic
        wb_valid = 1'b1; wb_rd = 5'd1; wb_data = 32'h0101_0101;
        md_valid = 1'b1; md_rd = 5'd8; md_data = 32'h0000_0808;
        expect_wr(5'd1, 32'h0101_0101);
        cyc();
        md_rd = 5'd9; md_data = 32'h0000_0909;
        expect_wr(5'd1, 32'h0101_0101);
        cyc();
        md_rd = 5'd10; md_data = 32'h0000_0A0A;
        expect_wr(5'd1, 32'h0101_0101);
        chk("full_count", {30'd0, fifo_count}, 32'd2);
        chk("full_md_ready", {31'd0, md_ready}, 32'd0);
        cyc();
        chk("full_held_count", {30'd0, fifo_count}, 32'd2);
        wb_valid = 1'b0;
        expect_wr(5'd8, 32'h0000_0808);
        cyc();
        md_valid = 1'b0;
        chk("full_ready_after_pop", {31'd0, md_ready}, 32'd1);
        chk("full_count_after_pop", {30'd0, fifo_count}, 32'd1);
        expect_wr(5'd9, 32'h0000_0909);
        cyc();
        chk("full_count_empty", {30'd0, fifo_count}, 32'd0);

        // Zero-register result is consumed without a push
        md_valid = 1'b1; md_rd = 5'd0; md_data = 32'h0000_DEAD;
        #1;
        chk("zero_md_ready", {31'd0, md_ready}, 32'd1);
        cyc();
        chk("zero_count", {30'd0, fifo_count}, 32'd0);
        md_rd = 5'd12; md_data = 32'h0000_0055;
        cyc();
        md_valid = 1'b0;
        wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
        expect_wr(5'd12, 32'h0000_0055);
        cyc();
        wb_valid = 1'b0;
        chk("wb_x0_drain_count", {30'd0, fifo_count}, 32'd0);

        // Set wins over a same-cycle clear
        md_issue = 1'b1; md_issue_rd = 5'd4;
        cyc();
        md_issue = 1'b0;
        md_valid = 1'b1; md_rd = 5'd4; md_data = 32'h0000_0044;
        cyc();
        md_valid = 1'b0;
        md_issue = 1'b1; md_issue_rd = 5'd4;
        expect_wr(5'd4, 32'h0000_0044);
        cyc();
        md_issue = 1'b0;
        chk("setclr_pending4", {31'd0, pending[4]}, 32'd1);
        chk("setclr_count", {30'd0, fifo_count}, 32'd0);

        // Wrap-around: back-to-back push/pop pairs
        for (int i = 0; i < 10; i++) begin
            md_valid = 1'b1;
            md_rd    = 5'(16 + i);
            md_data  = 32'h0000_1000 + 32'(i);
            expect_wr(5'(16 + i), 32'h0000_1000 + 32'(i));
            cyc();
            if (i == 5) begin
                chk("wrap_count_steady", {30'd0, fifo_count}, 32'd1);
            end
        end
        md_valid = 1'b0;
        cyc();
        chk("wrap_count_empty", {30'd0, fifo_count}, 32'd0);

        repeat (3) cyc();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
